gf_exp_rr_sched: RTL and testbench

// - Shares one combinational GF_exp (alpha^e, GF(2^8), poly 0x11D) among N_REQ requesters.
// - Round-robin arbitration, valid/ready on both sides, 2-stage registered pipeline.
// - Sits between the RS encoder/decoder front-ends and the single antilog table instance.

---
 rtl/gf_pkg.sv | 43 ++++
 rtl/gf_rr_arbiter.sv | 36 +++
 rtl/gf_exp_rr_sched.sv | 116 +++++++++++
 tb/tb_gf_exp_rr_sched.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// ============================================================================
// Module   : gf_pkg
// Brief    : GF(2^8) constants, element type and multiply/exponent helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gf_pkg;

   localparam int         GF_W     = 8;
   localparam int         GF_ORDER = 255;
   localparam logic [8:0] GF_POLY  = 9'h11D;

   typedef logic [GF_W-1:0] gf_elem_t;

   function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b);
      gf_elem_t acc;
      gf_elem_t x;
      acc = '0;
      x   = a;
      for (int k = 0; k < GF_W; k++) begin
         if (b[k]) acc = acc ^ x;
         x = x[GF_W-1] ? (gf_elem_t'(x << 1) ^ GF_POLY[GF_W-1:0]) : gf_elem_t'(x << 1);
      end
      return acc;
   endfunction

   // alpha^e as a product of alpha^(2^k) for each set exponent bit
   function automatic gf_elem_t gf_exp(input gf_elem_t e);
      gf_elem_t r;
      gf_elem_t base;
      r    = gf_elem_t'(1);
      base = gf_elem_t'(2);
      for (int k = 0; k < GF_W; k++) begin
         if (e[k]) r = gf_mul(r, base);
         base = gf_mul(base, base);
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gf_rr_arbiter.sv
// ============================================================================
// Module   : gf_rr_arbiter
// Brief    : Round-robin search from ptr+1 upward; one-hot grant plus index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_grant,
   output logic [ID_W-1:0]  o_idx
);

   logic [ID_W-1:0] w_j;

   // Walk farthest-first so the nearest requester after the pointer wins last.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_j     = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_j = ID_W'((int'(i_ptr) + k) % N_REQ);
         if (i_req[w_j]) begin
            o_grant = N_REQ'(1) << w_j;
            o_idx   = w_j;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/gf_exp_rr_sched.sv
// ============================================================================
// Module   : gf_exp_rr_sched
// Brief    : Round-robin shared alpha^e unit, 2-stage valid/ready pipeline.
//            Optional per-requester grant counters: GF_EXP_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_exp_rr_sched
   import gf_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*8-1:0]   req_exp,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ID_W-1:0]      resp_id,
   output logic [7:0]           resp_data
`ifdef GF_EXP_SCHED_STATS_EN
   ,
   output logic [N_REQ*16-1:0]  grant_cnt
`endif
);

   logic [N_REQ-1:0] w_grant;
   logic [ID_W-1:0]  w_idx;
   logic [N_REQ-1:0] w_ready;
   logic             w_adv1;
   logic             w_adv2;
   logic             w_hs;
   gf_elem_t         w_sel_exp;
   gf_elem_t         w_red_exp;
   gf_elem_t         w_exp_out;

   logic [ID_W-1:0]  r_ptr;
   logic             r_s1_valid;
   logic [ID_W-1:0]  r_s1_id;
   gf_elem_t         r_s1_exp;
   logic             r_resp_valid;
   logic [ID_W-1:0]  r_resp_id;
   gf_elem_t         r_resp_data;

   gf_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   assign w_adv2    = !r_resp_valid || resp_ready;
   assign w_adv1    = !r_s1_valid || w_adv2;
   // Ready is masked during reset so nothing is accepted into a pipe being flushed.
   assign w_ready   = w_grant & {N_REQ{w_adv1 && !rst}};
   assign w_hs      = |w_ready;
   assign w_sel_exp = req_exp[int'(w_idx)*8 +: 8];
   assign w_red_exp = (r_s1_exp == 8'hFF) ? 8'h00 : r_s1_exp;
   assign w_exp_out = gf_exp(w_red_exp);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr        <= ID_W'(N_REQ - 1);
         r_s1_valid   <= 1'b0;
         r_s1_id      <= '0;
         r_s1_exp     <= '0;
         r_resp_valid <= 1'b0;
         r_resp_id    <= '0;
         r_resp_data  <= '0;
      end else begin
         if (w_adv1) begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
               r_s1_id  <= w_idx;
               r_s1_exp <= w_sel_exp;
               r_ptr    <= w_idx;
            end
         end
         if (w_adv2) begin
            r_resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_resp_id   <= r_s1_id;
               r_resp_data <= w_exp_out;
            end
         end
      end
   end

   assign req_ready  = w_ready;
   assign resp_valid = r_resp_valid;
   assign resp_id    = r_resp_id;
   assign resp_data  = r_resp_data;

`ifdef GF_EXP_SCHED_STATS_EN
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      logic [15:0] r_cnt;
      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt <= '0;
         end else if (w_ready[gi] && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
      assign grant_cnt[gi*16 +: 16] = r_cnt;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gf_exp_rr_sched.sv
// ============================================================================
// Module   : tb_gf_exp_rr_sched
// Brief    : Scoreboard bench: queue-based reference model of the shared unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf_exp_rr_sched;

   localparam int N = 4;
   localparam int W = 2;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*8-1:0] req_exp;
   logic [N-1:0]   req_ready;
   logic           resp_valid;
   logic           resp_ready;
   logic [W-1:0]   resp_id;
   logic [7:0]     resp_data;

   gf_exp_rr_sched #(.N_REQ(N), .ID_W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_exp    (req_exp),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      int data;
      int hs;
   } item_t;

   item_t    q[$];
   item_t    it;
   int       alpha_pow[255];
   int       checks = 0;
   int       errors = 0;
   int       cyc_n  = 0;
   int       ptr_m  = N - 1;
   int       exp_g;
   int       hs_id;
   logic [N-1:0] exp_rdy;
   logic [N-1:0] hs_vec;
   logic     exp_rv;
   logic     prev_stall = 1'b0;
   logic [7:0] held_d;
   logic [W-1:0] held_id;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // Monitor: samples 1 time unit before each rising edge.
   always @(negedge clk) begin
      #4;
      cyc_n++;
      if (rst) begin
         check("rst_req_ready", 32'(req_ready), 32'd0);
         q.delete();
         ptr_m      = N - 1;
         prev_stall = 1'b0;
      end else begin
         exp_g = -1;
         for (int k = N; k >= 1; k--)
            if (req_valid[(ptr_m + k) % N]) exp_g = (ptr_m + k) % N;
         exp_rdy = '0;
         if (exp_g >= 0 && (q.size() < 2 || resp_ready)) exp_rdy[exp_g] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(exp_rdy));

         exp_rv = (q.size() > 0) && (cyc_n >= q[0].hs + 2);
         check("resp_valid", 32'(resp_valid), 32'(exp_rv));

         if (prev_stall) begin
            check("hold_data", 32'(resp_data), 32'(held_d));
            check("hold_id", 32'(resp_id), 32'(held_id));
         end

         if (resp_valid && resp_ready && q.size() > 0) begin
            it = q.pop_front();
            check("resp_id", 32'(resp_id), 32'(it.id));
            check("resp_data", 32'(resp_data), 32'(it.data));
         end

         prev_stall = resp_valid && !resp_ready;
         held_d     = resp_data;
         held_id    = resp_id;

         hs_vec = req_ready & req_valid;
         if (hs_vec != '0) begin
            hs_id = 0;
            for (int k = 0; k < N; k++) if (hs_vec[k]) hs_id = k;
            it.id   = hs_id;
            it.data = alpha_pow[int'(req_exp[hs_id*8 +: 8]) % 255];
            it.hs   = cyc_n;
            q.push_back(it);
            ptr_m = hs_id;
         end
      end
   end

   task automatic all_valid_rand();
      req_valid = '1;
      req_exp   = $urandom;
   endtask

   initial begin
      alpha_pow[0] = 1;
      for (int k = 1; k < 255; k++) begin
         alpha_pow[k] = alpha_pow[k-1] * 2;
         if (alpha_pow[k] > 255) alpha_pow[k] = alpha_pow[k] ^ 'h11D;
      end

      rst        = 1'b1;
      req_valid  = '0;
      req_exp    = '0;
      resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #4;
      check("reset_resp_valid", 32'(resp_valid), 32'd0);
      check("reset_resp_id", 32'(resp_id), 32'd0);
      check("reset_resp_data", 32'(resp_data), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);

      // req0 exp 0, then req1 exp 8/9 back-to-back
      @(negedge clk); req_valid = 4'b0001; req_exp = '0;
      @(negedge clk); req_valid = '0;
      repeat (3) @(negedge clk);
      req_valid = 4'b0010; req_exp[15:8] = 8'h08;
      @(negedge clk); req_exp[15:8] = 8'h09;
      @(negedge clk); req_valid = '0;
      repeat (3) @(negedge clk);

      // all requesters continuously valid: rotation 0,1,2,3,...
      for (int c = 0; c < 20; c++) begin all_valid_rand(); @(negedge clk); end
      req_valid = '0;
      repeat (3) @(negedge clk);

      // boundary exponents
      req_valid = 4'b1100; req_exp = {8'h07, 8'hFF, 16'h0};
      repeat (2) @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);

      // consumer stall with everyone requesting, then release
      resp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin all_valid_rand(); @(negedge clk); end
      resp_ready = 1'b1;
      req_valid  = '0;
      repeat (6) @(negedge clk);

      // reset with both stages full
      resp_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin all_valid_rand(); @(negedge clk); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; resp_ready = 1'b1;
      #4;
      check("rst_flush_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_first_grant", 32'(req_ready), 32'd1);
      for (int c = 0; c < 4; c++) begin @(negedge clk); all_valid_rand(); end
      @(negedge clk);

      // randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 199) == 0);
         req_valid  = N'($urandom);
         req_exp    = $urandom;
         resp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end

      rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
      repeat (6) @(negedge clk);
      #4;
      check("drain_empty", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
